// File: rtl/event_sram.sv
// event_sram: single-port-per-direction event SRAM with a post-reset clear
// sweep, a fully pipelined read path of RD_LAT cycles, and a write-first
// bypass when a read and a write hit the same word in the same cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   wr_en      write request (ignored while the sweep runs)
//   wr_addr    write address; writes to addresses >= DEPTH are dropped
//   wr_data    write data
//   rd_en      read request (ignored while the sweep runs)
//   rd_addr    read address; addresses >= DEPTH read as 0
//   rd_data    registered read data, holds between rd_valid pulses
//   rd_valid   one-cycle pulse qualifying rd_data, RD_LAT cycles after rd_en
//   init_busy  high while the clear sweep runs
//   par_err    sticky parity error (only with EVENT_SRAM_PARITY_EN)
//
// Optional feature macro: EVENT_SRAM_PARITY_EN adds one even-parity bit per
// word and the par_err output.

`ifndef EVENT_BITS
`define EVENT_BITS 8
`endif
`ifndef EVENT_QUEUE_DEPTH
`define EVENT_QUEUE_DEPTH 16
`endif

module event_sram #(
  parameter int unsigned DATA_W = `EVENT_BITS,
  parameter int unsigned DEPTH  = `EVENT_QUEUE_DEPTH,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              init_busy
`ifdef EVENT_SRAM_PARITY_EN
  ,
  output logic              par_err
`endif
);

`ifdef EVENT_SRAM_PARITY_EN
  localparam int unsigned MW = DATA_W + 1;
`else
  localparam int unsigned MW = DATA_W;
`endif

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     mem_q [DEPTH];

  logic              mem_we_c;
  logic [AW-1:0]     mem_waddr_c;
  logic [MW-1:0]     mem_wdata_c;
  logic              rd_acc_c;
  logic [MW-1:0]     rd_word_c;
  logic              wr_in_range_c;
  logic              rd_in_range_c;

  logic [RD_LAT-1:0]             pv_q;
  logic [RD_LAT-1:0][DATA_W-1:0] pd_q;

  assign wr_in_range_c = 32'(wr_addr) < DEPTH;
  assign rd_in_range_c = 32'(rd_addr) < DEPTH;

  // FSM state register and sweep counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: sweep DEPTH words, then stay in READY until reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = ST_READY;
        cnt_d   = '0;
      end
    end
  end

  // FSM outputs: sweep owns the write port in INIT, user ports in READY
  always_comb begin
    init_busy   = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr;
`ifdef EVENT_SRAM_PARITY_EN
    mem_wdata_c = {^wr_data, wr_data};
`else
    mem_wdata_c = wr_data;
`endif
    rd_acc_c    = 1'b0;
    if (state_q == ST_INIT) begin
      init_busy   = 1'b1;
      mem_we_c    = !rst;
      mem_waddr_c = cnt_q;
      mem_wdata_c = '0;
    end else begin
      mem_we_c = !rst && wr_en && wr_in_range_c;
      rd_acc_c = !rst && rd_en;
    end
  end

  // Storage array; contents are defined only by the sweep and user writes
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Read lookup with write-first bypass; out-of-range reads return zero
  always_comb begin
    rd_word_c = '0;
    if (rd_in_range_c) begin
      rd_word_c = mem_q[rd_addr];
      if (mem_we_c && (mem_waddr_c == rd_addr)) begin
        rd_word_c = mem_wdata_c;
      end
    end
  end

  // Read pipeline; each stage loads data only with a valid so the
  // last stage (rd_data) holds between pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      pd_q <= '0;
    end else begin
      pv_q[0] <= rd_acc_c;
      if (rd_acc_c) begin
        pd_q[0] <= rd_word_c[DATA_W-1:0];
      end
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) begin
          pd_q[i] <= pd_q[i-1];
        end
      end
    end
  end

  assign rd_valid = pv_q[RD_LAT-1];
  assign rd_data  = pd_q[RD_LAT-1];

`ifdef EVENT_SRAM_PARITY_EN
  // Even parity over {parity, data} is zero for an intact word
  logic              rd_perr_c;
  logic [RD_LAT-1:0] pe_q;
  logic              last_in_v_c;
  logic              last_in_pe_c;
  logic              par_err_q;

  assign rd_perr_c = ^rd_word_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pe_q <= '0;
    end else begin
      pe_q[0] <= rd_acc_c & rd_perr_c;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pe_q[i] <= pe_q[i-1];
      end
    end
  end

  // Flag rises on the same edge that raises rd_valid for the bad read
  if (RD_LAT == 1) begin : g_pe_lat1
    assign last_in_v_c  = rd_acc_c;
    assign last_in_pe_c = rd_perr_c;
  end else begin : g_pe_latn
    assign last_in_v_c  = pv_q[RD_LAT-2];
    assign last_in_pe_c = pe_q[RD_LAT-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else if (last_in_v_c && last_in_pe_c) begin
      par_err_q <= 1'b1;
    end
  end

  assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_event_sram.sv
// Self-checking bench for event_sram: three instances with different
// DEPTH/RD_LAT share one stimulus stream and are compared each cycle
// against a time-scheduled behavioural model.
module tb_event_sram;

  localparam int NI = 3;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int M_DEPTH [NI] = '{16, 12, 9};
  localparam int M_LAT   [NI] = '{2, 1, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic [NI-1:0] o_valid, o_busy, o_perr;
  logic [DW-1:0] o_data [NI];

`ifndef EVENT_SRAM_PARITY_EN
  assign o_perr = '0;
`endif

  event_sram #(.DATA_W(DW), .DEPTH(16), .RD_LAT(2)) u_dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_data[0]), .rd_valid(o_valid[0]),
    .init_busy(o_busy[0])
`ifdef EVENT_SRAM_PARITY_EN
    , .par_err(o_perr[0])
`endif
  );

  event_sram #(.DATA_W(DW), .DEPTH(12), .RD_LAT(1)) u_dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_data[1]), .rd_valid(o_valid[1]),
    .init_busy(o_busy[1])
`ifdef EVENT_SRAM_PARITY_EN
    , .par_err(o_perr[1])
`endif
  );

  event_sram #(.DATA_W(DW), .DEPTH(9), .RD_LAT(3)) u_dut_c (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(o_data[2]), .rd_valid(o_valid[2]),
    .init_busy(o_busy[2])
`ifdef EVENT_SRAM_PARITY_EN
    , .par_err(o_perr[2])
`endif
  );

  // Reference model: memory image, words still to be swept, and read
  // results scheduled by the cycle in which they must appear.
  bit [DW-1:0] m_mem   [NI][16];
  bit          m_bad   [NI][16];
  int          m_init_left [NI];
  bit          sch_v   [NI][8];
  bit [DW-1:0] sch_d   [NI][8];
  bit          sch_pe  [NI][8];
  bit          e_valid [NI];
  bit [DW-1:0] e_data  [NI];
  bit          e_busy  [NI];
  bit          e_perr  [NI];
  int          cyc = 0;

  int n_vec = 0;
  int n_err = 0;
  string names [NI] = '{"a", "b", "c"};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled
  task automatic model_edge();
    bit          acc;
    bit [DW-1:0] v;
    bit          pe;
    int          slot;
    cyc++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_init_left[i] = M_DEPTH[i];
        for (int s = 0; s < 8; s++) sch_v[i][s] = 1'b0;
        e_valid[i] = 1'b0;
        e_data[i]  = '0;
        e_perr[i]  = 1'b0;
      end else begin
        acc = (m_init_left[i] == 0) && rd_en;
        if (m_init_left[i] > 0) begin
          m_mem[i][M_DEPTH[i] - m_init_left[i]] = '0;
          m_bad[i][M_DEPTH[i] - m_init_left[i]] = 1'b0;
          m_init_left[i]--;
        end else if (wr_en && (int'(wr_addr) < M_DEPTH[i])) begin
          m_mem[i][wr_addr] = wr_data;
          m_bad[i][wr_addr] = 1'b0;
        end
        if (acc) begin
          v  = (int'(rd_addr) < M_DEPTH[i]) ? m_mem[i][rd_addr] : '0;
          pe = (int'(rd_addr) < M_DEPTH[i]) ? m_bad[i][rd_addr] : 1'b0;
          slot = (cyc + M_LAT[i] - 1) % 8;
          sch_v[i][slot]  = 1'b1;
          sch_d[i][slot]  = v;
          sch_pe[i][slot] = pe;
        end
        slot = cyc % 8;
        e_valid[i] = sch_v[i][slot];
        if (sch_v[i][slot]) begin
          e_data[i] = sch_d[i][slot];
          if (sch_pe[i][slot]) e_perr[i] = 1'b1;
        end
        sch_v[i][slot] = 1'b0;
      end
      e_busy[i] = m_init_left[i] > 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check({names[i], ".init_busy"}, 32'(o_busy[i]), 32'(e_busy[i]));
      check({names[i], ".rd_valid"}, 32'(o_valid[i]), 32'(e_valid[i]));
      check({names[i], ".rd_data"}, 32'(o_data[i]), 32'(e_data[i]));
`ifdef EVENT_SRAM_PARITY_EN
      check({names[i], ".par_err"}, 32'(o_perr[i]), 32'(e_perr[i]));
`endif
    end
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic re, input logic [AW-1:0] ra);
    wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic rand_traffic();
    wr_en   = 1'($urandom_range(0, 1));
    rd_en   = 1'($urandom_range(0, 1));
    wr_addr = AW'($urandom_range(0, 15));
    wr_data = DW'($urandom);
    rd_addr = ($urandom_range(0, 1) == 1) ? wr_addr : AW'($urandom_range(0, 15));
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    for (int i = 0; i < NI; i++) m_init_left[i] = M_DEPTH[i];
    @(negedge clk);
    step();
    step();
    rst = 1'b0;

    // Traffic during the sweep must be ignored
    for (int k = 0; k < 8; k++) begin
      rand_traffic();
      step();
    end
    idle(10);

    // Every word reads back zero after the sweep
    for (int k = 0; k < 16; k++) drive(1'b0, '0, '0, 1'b1, AW'(k));
    idle(4);

    // Write then read at addr 3
    drive(1'b1, 4'd3, 8'hA5, 1'b0, '0);
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    idle(4);

    // Same-cycle write/read at addr 7 sees the new data
    drive(1'b1, 4'd7, 8'h11, 1'b0, '0);
    drive(1'b1, 4'd7, 8'h3C, 1'b1, 4'd7);
    idle(4);

    // Out-of-range write at 13 is dropped for the shallower instances
    drive(1'b1, 4'd13, 8'hFF, 1'b0, '0);
    for (int k = 0; k < 16; k++) drive(1'b0, '0, '0, 1'b1, AW'(k));
    idle(4);

    // Reset with reads in flight, then reset again mid-sweep
    drive(1'b0, '0, '0, 1'b1, 4'd3);
    drive(1'b0, '0, '0, 1'b1, 4'd7);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(18);

    // Random traffic with occasional resets
    for (int k = 0; k < 700; k++) begin
      rand_traffic();
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    idle(18);

`ifdef EVENT_SRAM_PARITY_EN
    // Corrupt the parity bit of addr 2 in instance a and read it back
    drive(1'b1, 4'd2, 8'h5A, 1'b0, '0);
    u_dut_a.mem_q[2][DW] = ~u_dut_a.mem_q[2][DW];
    m_bad[0][2] = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 4'd2);
    idle(6);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(18);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
